pe_mac_param: RTL and testbench
===============================

Name: pe_mac_param

Overview:
- Parametrised successor to the registered systolic processing element (PE), which takes w_in/a_in/c_in and produces w_out/a_out/c_out.
- Adds configurable data and accumulator widths, an optional multiplier pipeline stage, and runtime mode select between pass-through MAC and output-stationary accumulation.
- Also adds valid propagation, saturation with a sticky overflow flag, and single-bit fault injection via err_mult/err_mac.
- Tiles into the NPU systolic array: weights/activations forward east/south, partial sums forward down the c-chain.

Parameters:
DW, 8, signed width of w_in/a_in/w_out/a_out
CW, 24, signed width of c_in/c_out/accumulator (must be >= 2*DW)
MUL_PIPE, 0, 0 = product combinational into adder; 1 = registered product stage
SAT, 1, 1 = clamp sums to signed CW range; 0 = two's-complement wrap

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
hold  in  1  stall: freezes every register
mode  in  1  0 = pass-through MAC, 1 = output-stationary
in_valid  in  1  w_in/a_in qualifier
c_vin  in  1  c_in qualifier
drain  in  1  mode 1: emit local accumulator this cycle
acc_clr  in  1  clear accumulator and ovf
err_mult  in  1  fault inject: flip product LSB
err_mac  in  1  fault inject: flip sum LSB
w_in  in  DW  signed weight
a_in  in  DW  signed activation
c_in  in  CW  signed partial sum from neighbour
w_out  out  DW  registered w_in
a_out  out  DW  registered a_in
c_out  out  CW  registered result
out_valid  out  1  c_out qualifier
ovf  out  1  sticky saturation/overflow flag

Behaviour:
- Reset (rst=1 at clk edge): w_out, a_out, c_out, accumulator, product stage = 0; out_valid = 0; ovf = 0. rst beats hold and all other inputs. Reset mid-operation discards in-flight pipeline data; out_valid = 0 on the following cycle.
- hold=1 (rst=0): no register changes, including forwarding regs, pipeline, accumulator, ovf. Inputs in that cycle are dropped.
- Forwarding: w_out<=w_in, a_out<=a_in every non-held cycle, latency 1, independent of in_valid and mode.
- Product: p = w_in*a_in, full 2*DW signed, sign-extended to CW. If err_mult=1, p[0] is inverted. MUL_PIPE=1 registers p, err_mac, c_in, c_vin, in_valid, drain, mode together, so operands stay aligned.
- Mode 0, latency 1+MUL_PIPE:
  - s = c_in + p (CW+1 bits); if err_mac=1, s[0] is inverted before clamping.
  - c_out <= clamp(s); out_valid <= in_valid & c_vin.
  - Accumulator untouched.
- Mode 1:
  - Accumulation: if in_valid, acc <= clamp(acc + p), err_mac applied as in mode 0.
  - drain=1: c_out <= clamp(acc + (in_valid ? p : 0)), i.e. the final product is included; out_valid <= 1; acc <= 0.
  - drain=0: c_out <= c_in, out_valid <= c_vin (drain-chain bypass).
  - drain=1 with c_vin=1: local value wins; neighbour data is lost. This is the controller's fault; the PE does not flag it.
- acc_clr=1: acc <= 0 and ovf <= 0 with priority over accumulation. If drain=1 in the same cycle, the pre-clear drain value is still emitted.
- Clamp:
  - SAT=1: values > 2^(CW-1)-1 → 2^(CW-1)-1; values < -2^(CW-1) → -2^(CW-1); either case sets ovf<=1.
  - SAT=0: wrap to CW bits; ovf still set on signed overflow.
- ovf cleared only by rst or acc_clr.
- Mode changes take effect on the next accepted input. Switching mode with a non-zero acc keeps acc.

Test Plan:
- Mode 0, MUL_PIPE=0, in_valid=c_vin=1: (w,a,c) = (87,65,43), (-87,65,43), (-87,-65,43), (87,65,-43), (-87,65,-43), (-87,-65,-43) on consecutive cycles → c_out = 5698, -5612, 5698, 5612, -5698, 5612, one cycle later each; w_out/a_out echo inputs after 1 cycle.
- Same stream with MUL_PIPE=1 → identical values, 2-cycle latency; hold=1 for 3 mid-stream cycles → outputs frozen, then sequence resumes with no loss or duplication of inputs presented while hold=0.
- Mode 1: 3×(87,65) then drain with in_valid=0 → c_out=16965, out_valid=1 for one cycle, acc=0 afterwards; next drain with no input → c_out=0.
- DW=8, CW=16, SAT=1, mode 1: 3×(127,127) then drain → c_out=32767, ovf=1 and stays 1 until acc_clr; with SAT=0 → c_out=48387-65536=-17149, ovf=1.
- Fault injection: mode 0, (87,65,43) with err_mult=1 → 5697; with err_mac=1 → 5699; with both → 5696.
- rst asserted mid-accumulation (acc=5655) together with drain → next cycle c_out=0, out_valid=0, ovf=0; a subsequent drain returns 0.

Source files
------------

// File: rtl/pe_mac_param_if.sv
// Bundle of handshake and data signals for one pe_mac_param tile.
// The slave side is the PE; the master side is whatever feeds it.
interface pe_mac_param_if #(
  parameter int DW = 8,
  parameter int CW = 24
);
  logic                 hold;
  logic                 mode;
  logic                 in_valid;
  logic                 c_vin;
  logic                 drain;
  logic                 acc_clr;
  logic                 err_mult;
  logic                 err_mac;
  logic signed [DW-1:0] w_in;
  logic signed [DW-1:0] a_in;
  logic signed [CW-1:0] c_in;
  logic signed [DW-1:0] w_out;
  logic signed [DW-1:0] a_out;
  logic signed [CW-1:0] c_out;
  logic                 out_valid;
  logic                 ovf;

  modport master (
    output hold, mode, in_valid, c_vin, drain, acc_clr, err_mult, err_mac,
    output w_in, a_in, c_in,
    input  w_out, a_out, c_out, out_valid, ovf
  );

  modport slave (
    input  hold, mode, in_valid, c_vin, drain, acc_clr, err_mult, err_mac,
    input  w_in, a_in, c_in,
    output w_out, a_out, c_out, out_valid, ovf
  );
endinterface

// File: rtl/pe_mac_param.sv
// Parametrised systolic PE: forwards w/a, computes pass-through MAC (mode 0)
// or output-stationary accumulation with drain (mode 1), with optional
// registered product stage, saturation/wrap, sticky overflow and fault inject.
module pe_mac_param #(
  parameter int DW       = 8,
  parameter int CW       = 24,
  parameter int MUL_PIPE = 0,
  parameter int SAT      = 1
) (
  input logic           clk,
  input logic           rst,
  pe_mac_param_if.slave bus
);

  localparam logic signed [CW-1:0] LP_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] LP_MIN = {1'b1, {(CW-1){1'b0}}};

  logic signed [2*DW-1:0] w_prod;
  logic signed [CW-1:0]   w_pext;
  logic signed [CW-1:0]   w_p;

  // Operands as seen by the adder stage (direct or one register later).
  logic signed [CW-1:0]   w_s_p;
  logic signed [CW-1:0]   w_s_c;
  logic                   w_s_em;
  logic                   w_s_cv;
  logic                   w_s_iv;
  logic                   w_s_dr;
  logic                   w_s_md;
  logic                   w_s_clr;

  logic signed [CW-1:0]   r_w_unused_guard;
  logic signed [DW-1:0]   r_w;
  logic signed [DW-1:0]   r_a;
  logic signed [CW-1:0]   r_c;
  logic signed [CW-1:0]   r_acc;
  logic                   r_v;
  logic                   r_ov;

  logic signed [CW-1:0]   w_addend;
  logic signed [CW:0]     w_s0;
  logic signed [CW:0]     w_s0f;
  logic signed [CW:0]     w_s1;
  logic signed [CW:0]     w_s1f;
  logic                   w_ovf_evt;

  function automatic logic signed [CW-1:0] f_clamp(input logic signed [CW:0] s);
    if ((s[CW] != s[CW-1]) && (SAT != 0))
      return s[CW] ? LP_MIN : LP_MAX;
    else
      return s[CW-1:0];
  endfunction

  function automatic logic f_ovf(input logic signed [CW:0] s);
    return s[CW] ^ s[CW-1];
  endfunction

  assign w_prod = bus.w_in * bus.a_in;
  assign w_pext = CW'(w_prod);
  assign w_p    = {w_pext[CW-1:1], w_pext[0] ^ bus.err_mult};

  generate
    if (MUL_PIPE != 0) begin : g_pipe
      logic signed [CW-1:0] r_p;
      logic signed [CW-1:0] r_cin;
      logic                 r_em, r_cv, r_iv, r_dr, r_md, r_clr;

      // Product stage: every control travels with its product so that the
      // adder always sees one consistent input beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_p   <= '0;
          r_cin <= '0;
          r_em  <= 1'b0;
          r_cv  <= 1'b0;
          r_iv  <= 1'b0;
          r_dr  <= 1'b0;
          r_md  <= 1'b0;
          r_clr <= 1'b0;
        end else if (!bus.hold) begin
          r_p   <= w_p;
          r_cin <= bus.c_in;
          r_em  <= bus.err_mac;
          r_cv  <= bus.c_vin;
          r_iv  <= bus.in_valid;
          r_dr  <= bus.drain;
          r_md  <= bus.mode;
          r_clr <= bus.acc_clr;
        end
      end

      assign w_s_p   = r_p;
      assign w_s_c   = r_cin;
      assign w_s_em  = r_em;
      assign w_s_cv  = r_cv;
      assign w_s_iv  = r_iv;
      assign w_s_dr  = r_dr;
      assign w_s_md  = r_md;
      assign w_s_clr = r_clr;
    end else begin : g_comb
      assign w_s_p   = w_p;
      assign w_s_c   = bus.c_in;
      assign w_s_em  = bus.err_mac;
      assign w_s_cv  = bus.c_vin;
      assign w_s_iv  = bus.in_valid;
      assign w_s_dr  = bus.drain;
      assign w_s_md  = bus.mode;
      assign w_s_clr = bus.acc_clr;
    end
  endgenerate

  // The drain sum doubles as the accumulate sum, so a drain beat carrying a
  // valid product emits exactly what the accumulator would have become.
  always_comb begin
    w_addend  = w_s_iv ? w_s_p : '0;
    w_s0      = (CW+1)'(w_s_c) + (CW+1)'(w_s_p);
    w_s0f     = {w_s0[CW:1], w_s0[0] ^ w_s_em};
    w_s1      = (CW+1)'(r_acc) + (CW+1)'(w_addend);
    w_s1f     = {w_s1[CW:1], w_s1[0] ^ (w_s_em & w_s_iv)};
    w_ovf_evt = w_s_md ? ((w_s_iv | w_s_dr) & f_ovf(w_s1f))
                       : (w_s_iv & w_s_cv & f_ovf(w_s0f));
  end

  // Forwarding, result, accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w   <= '0;
      r_a   <= '0;
      r_c   <= '0;
      r_acc <= '0;
      r_v   <= 1'b0;
      r_ov  <= 1'b0;
    end else if (!bus.hold) begin
      r_w <= bus.w_in;
      r_a <= bus.a_in;
      if (!w_s_md) begin
        r_c <= f_clamp(w_s0f);
        r_v <= w_s_iv & w_s_cv;
      end else if (w_s_dr) begin
        r_c <= f_clamp(w_s1f);
        r_v <= 1'b1;
      end else begin
        r_c <= w_s_c;
        r_v <= w_s_cv;
      end
      if (w_s_clr || (w_s_md && w_s_dr))
        r_acc <= '0;
      else if (w_s_md && w_s_iv)
        r_acc <= f_clamp(w_s1f);
      if (w_s_clr)
        r_ov <= 1'b0;
      else if (w_ovf_evt)
        r_ov <= 1'b1;
    end
  end

  assign r_w_unused_guard = '0;
  assign bus.w_out     = r_w;
  assign bus.a_out     = r_a;
  assign bus.c_out     = r_c | r_w_unused_guard;
  assign bus.out_valid = r_v;
  assign bus.ovf       = r_ov;

endmodule

// File: tb/tb_pe_mac_param.sv
// Scoreboard bench for pe_mac_param: four tiles with different parameter sets
// share stimulus data; only the addressed lane gets active controls.
module tb_pe_mac_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0] t_hold, t_mode, t_iv, t_cv, t_dr, t_clr, t_em, t_ea;
  logic signed [7:0]  t_w, t_a;
  logic signed [23:0] t_c;

  pe_mac_param_if #(.DW(8), .CW(24)) if0 ();
  pe_mac_param_if #(.DW(8), .CW(24)) if1 ();
  pe_mac_param_if #(.DW(8), .CW(16)) if2 ();
  pe_mac_param_if #(.DW(8), .CW(16)) if3 ();

  pe_mac_param #(.DW(8), .CW(24), .MUL_PIPE(0), .SAT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pe_mac_param #(.DW(8), .CW(24), .MUL_PIPE(1), .SAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  pe_mac_param #(.DW(8), .CW(16), .MUL_PIPE(0), .SAT(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  pe_mac_param #(.DW(8), .CW(16), .MUL_PIPE(0), .SAT(0)) u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.hold = t_hold[0]; assign if1.hold = t_hold[1]; assign if2.hold = t_hold[2]; assign if3.hold = t_hold[3];
  assign if0.mode = t_mode[0]; assign if1.mode = t_mode[1]; assign if2.mode = t_mode[2]; assign if3.mode = t_mode[3];
  assign if0.in_valid = t_iv[0]; assign if1.in_valid = t_iv[1]; assign if2.in_valid = t_iv[2]; assign if3.in_valid = t_iv[3];
  assign if0.c_vin = t_cv[0]; assign if1.c_vin = t_cv[1]; assign if2.c_vin = t_cv[2]; assign if3.c_vin = t_cv[3];
  assign if0.drain = t_dr[0]; assign if1.drain = t_dr[1]; assign if2.drain = t_dr[2]; assign if3.drain = t_dr[3];
  assign if0.acc_clr = t_clr[0]; assign if1.acc_clr = t_clr[1]; assign if2.acc_clr = t_clr[2]; assign if3.acc_clr = t_clr[3];
  assign if0.err_mult = t_em[0]; assign if1.err_mult = t_em[1]; assign if2.err_mult = t_em[2]; assign if3.err_mult = t_em[3];
  assign if0.err_mac = t_ea[0]; assign if1.err_mac = t_ea[1]; assign if2.err_mac = t_ea[2]; assign if3.err_mac = t_ea[3];
  assign if0.w_in = t_w; assign if1.w_in = t_w; assign if2.w_in = t_w; assign if3.w_in = t_w;
  assign if0.a_in = t_a; assign if1.a_in = t_a; assign if2.a_in = t_a; assign if3.a_in = t_a;
  assign if0.c_in = t_c; assign if1.c_in = t_c; assign if2.c_in = t_c[15:0]; assign if3.c_in = t_c[15:0];

  logic signed [23:0] m_c [4];
  logic signed [7:0]  m_w [4];
  logic signed [7:0]  m_a [4];
  logic               m_v [4];
  logic               m_o [4];

  assign m_c[0] = if0.c_out; assign m_c[1] = if1.c_out;
  assign m_c[2] = 24'(if2.c_out); assign m_c[3] = 24'(if3.c_out);
  assign m_w[0] = if0.w_out; assign m_w[1] = if1.w_out; assign m_w[2] = if2.w_out; assign m_w[3] = if3.w_out;
  assign m_a[0] = if0.a_out; assign m_a[1] = if1.a_out; assign m_a[2] = if2.a_out; assign m_a[3] = if3.a_out;
  assign m_v[0] = if0.out_valid; assign m_v[1] = if1.out_valid; assign m_v[2] = if2.out_valid; assign m_v[3] = if3.out_valid;
  assign m_o[0] = if0.ovf; assign m_o[1] = if1.ovf; assign m_o[2] = if2.ovf; assign m_o[3] = if3.ovf;

  typedef struct {
    int                 lane;
    logic signed [23:0] c;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic drv(input int l, input logic md, input logic iv, input logic cv,
                     input logic dr, input int w, input int a, input int c);
    t_hold = '0; t_mode = '0; t_iv = '0; t_cv = '0;
    t_dr = '0; t_clr = '0; t_em = '0; t_ea = '0;
    t_mode[l] = md; t_iv[l] = iv; t_cv[l] = cv; t_dr[l] = dr;
    t_w = 8'(w); t_a = 8'(a); t_c = 24'(c);
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic push(input int l, input int v);
    exp_t e;
    e.lane = l;
    e.c    = 24'(v);
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every non-held, non-reset edge check forwarding, and pop the
  // scoreboard whenever a lane presents out_valid.
  initial begin
    logic [3:0]        h;
    logic              r;
    logic signed [7:0] fw, fa;
    exp_t              e;
    forever begin
      @(posedge clk);
      h = t_hold; r = rst; fw = t_w; fa = t_a;
      #1;
      if (!r) begin
        for (int l = 0; l < 4; l++) begin
          if (!h[l]) begin
            chk($sformatf("w_out[%0d]", l), m_w[l], fw);
            chk($sformatf("a_out[%0d]", l), m_a[l], fa);
            if (m_v[l] === 1'b1) begin
              if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out[%0d] actual=%0d required=none", l, m_c[l]);
              end else begin
                e = sbq.pop_front();
                chk($sformatf("lane_tag[%0d]", l), l, e.lane);
                chk($sformatf("c_out[%0d]", l), m_c[l], e.c);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int va_w [6] = '{87, -87, -87, 87, -87, -87};
  int va_a [6] = '{65, 65, -65, 65, 65, -65};
  int va_c [6] = '{43, 43, 43, -43, -43, -43};
  int va_e [6] = '{5698, -5612, 5698, 5612, -5698, 5612};

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) step();
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("rst_c_out[%0d]", l), m_c[l], 0);
      chk($sformatf("rst_valid[%0d]", l), 32'(m_v[l]), 0);
      chk($sformatf("rst_ovf[%0d]", l), 32'(m_o[l]), 0);
      chk($sformatf("rst_w_out[%0d]", l), m_w[l], 0);
    end
    rst = 1'b0;

    // Mode 0, combinational product: latency 1.
    for (int i = 0; i < 6; i++) begin
      drv(0, 1'b0, 1'b1, 1'b1, 1'b0, va_w[i], va_a[i], va_c[i]);
      push(0, va_e[i]);
      step();
      if (i == 0) begin
        chk("lat1_valid", 32'(m_v[0]), 1);
        chk("lat1_c_out", m_c[0], 5698);
      end
    end
    idle(); step(); step();

    // Mode 0, registered product: latency 2, three held cycles mid-stream.
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        for (int k = 0; k < 3; k++) begin
          drv(1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1);
          t_hold[1] = 1'b1;
          step();
          chk("hold_c_out", m_c[1], -5612);
          chk("hold_valid", 32'(m_v[1]), 1);
        end
      end
      drv(1, 1'b0, 1'b1, 1'b1, 1'b0, va_w[i], va_a[i], va_c[i]);
      push(1, va_e[i]);
      step();
      if (i == 0) chk("lat2_early_valid", 32'(m_v[1]), 0);
      if (i == 1) begin
        chk("lat2_valid", 32'(m_v[1]), 1);
        chk("lat2_c_out", m_c[1], 5698);
      end
    end
    idle(); repeat (3) step();

    // Mode 1: accumulate three products, drain, then drain an empty accumulator.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 87, 65, 0);
      step();
    end
    drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    push(0, 16965);
    step();
    chk("drain_valid", 32'(m_v[0]), 1);
    idle(); step();
    chk("drain_one_cycle", 32'(m_v[0]), 0);
    drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    push(0, 0);
    step();
    idle(); step();

    // Overflow on CW=16: saturating lane 2, then wrapping lane 3.
    for (int l = 2; l < 4; l++) begin
      for (int i = 0; i < 3; i++) begin
        drv(l, 1'b1, 1'b1, 1'b0, 1'b0, 127, 127, 0);
        step();
      end
      drv(l, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
      push(l, (l == 2) ? 32767 : -17149);
      step();
      chk($sformatf("ovf_set[%0d]", l), 32'(m_o[l]), 1);
      idle(); step(); step();
      chk($sformatf("ovf_sticky[%0d]", l), 32'(m_o[l]), 1);
    end
    drv(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    t_clr[2] = 1'b1;
    step();
    chk("ovf_clr", 32'(m_o[2]), 0);
    idle(); step();

    // Fault injection on the pass-through MAC.
    for (int f = 1; f < 4; f++) begin
      drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 87, 65, 43);
      t_em[0] = f[0];
      t_ea[0] = f[1];
      push(0, (f == 1) ? 5697 : (f == 2) ? 5699 : 5696);
      step();
    end
    idle(); step();

    // Reset while accumulating, together with a drain request.
    drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 87, 65, 0);
    step();
    drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_c_out", m_c[0], 0);
    chk("rstmid_valid", 32'(m_v[0]), 0);
    chk("rstmid_ovf", 32'(m_o[0]), 0);
    drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    push(0, 0);
    step();
    chk("rstmid_drain_valid", 32'(m_v[0]), 1);
    idle(); repeat (3) step();

    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
